// File: rtl/dmem_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | dmem_arbiter_pkg                                                     |
// | FSM state encodings and port ids shared by the data-memory arbiter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package dmem_arbiter_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_arb2_rr.sv
// +----------------------------------------------------------------------+
// | arb2_rr                                                              |
// | Two-requester picker: round-robin on last grant or fixed CPU win.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module arb2_rr
  import dmem_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  input  logic i_cpu_prio,
  output logic o_valid,
  output logic o_winner
);

  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = PORT_CPU;
    if (i_req0 && i_req1) begin
      o_winner = i_cpu_prio ? PORT_CPU : ~i_last;
    end else if (i_req1) begin
      o_winner = PORT_DMA;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +----------------------------------------------------------------------+
// | dmem_arbiter                                                         |
// | Shares a single-port data memory between the CPU and a DMA master.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int TIMEOUT  = 15,
  parameter bit CPU_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_gnt0,
  output logic          o_gnt1,
  output logic          o_done0,
  output logic          o_done1,
  output logic [DW-1:0] o_rdata0,
  output logic [DW-1:0] o_rdata1,
  output logic          o_err,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_done0;
  logic          r_done1;
  logic          r_err;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_valid;
  logic          w_winner;
  logic          w_accept;
  logic          w_ack;
  logic          w_timeout;
  logic          w_finish;
  logic [CW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_cap_data;

  arb2_rr u_arb (
    .i_req0     (i_req0),
    .i_req1     (i_req1),
    .i_last     (r_last),
    .i_cpu_prio (CPU_PRIO),
    .o_valid    (w_valid),
    .o_winner   (w_winner)
  );

  assign w_accept  = (r_state == ST_IDLE) && w_valid;
  assign w_ack     = (r_state == ST_ACCESS) && i_mem_ack;
  assign w_cnt_nxt = r_cnt + CW'(1);
  // Abort on the TIMEOUT-th ACCESS cycle; a coincident ack takes precedence.
  assign w_timeout = (r_state == ST_ACCESS) && !i_mem_ack && (w_cnt_nxt == CW'(TIMEOUT));
  assign w_finish  = w_ack || w_timeout;
  assign w_cap_data = (w_ack && !r_we) ? i_mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_finish) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_gnt0      = 1'b0;
    o_gnt1      = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (r_state)
      ST_IDLE: begin
        o_gnt0 = w_valid && (w_winner == PORT_CPU);
        o_gnt1 = w_valid && (w_winner == PORT_DMA);
      end
      ST_ACCESS: begin
        o_mem_en    = 1'b1;
        o_mem_we    = r_we;
        o_mem_addr  = r_addr;
        o_mem_wdata = r_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner  <= PORT_CPU;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_last   <= PORT_DMA;
      r_cnt    <= '0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err    <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      if (w_accept) begin
        r_owner <= w_winner;
        r_we    <= w_winner ? i_we1 : i_we0;
        r_addr  <= w_winner ? i_addr1 : i_addr0;
        r_wdata <= w_winner ? i_wdata1 : i_wdata0;
        r_last  <= w_winner;
        r_cnt   <= '0;
      end else if (r_state == ST_ACCESS) begin
        r_cnt <= w_cnt_nxt;
      end
      if (w_finish) begin
        r_err <= w_timeout;
        if (r_owner == PORT_CPU) begin
          r_done0  <= 1'b1;
          r_rdata0 <= w_cap_data;
        end else begin
          r_done1  <= 1'b1;
          r_rdata1 <= w_cap_data;
        end
      end
    end
  end

  assign o_done0  = r_done0;
  assign o_done1  = r_done1;
  assign o_err    = r_err;
  assign o_rdata0 = r_rdata0;
  assign o_rdata1 = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter                                                      |
// | Scoreboard bench for a round-robin and a CPU-priority arbiter.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic          port;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [DW-1:0] rd_drv = '0;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          gnt0, gnt1, done0, done1, err, mem_en, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          p_gnt0, p_gnt1, p_done0, p_done1, p_err, p_mem_en, p_mem_we;
  logic [DW-1:0] p_rdata0, p_rdata1, p_mem_wdata;
  logic [AW-1:0] p_mem_addr;

  int   ack_mode = 0;   // 0 immediate, 1 never, 2 on ack_at-th mem_en cycle
  int   ack_at = 1;
  int   en_cnt = 0;
  int   en_last = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q_rr[$];
  exp_t q_p[$];

  assign mem_rdata = rd_drv;
  assign mem_ack = mem_en && (ack_mode == 0 || (ack_mode == 2 && en_cnt == ack_at - 1));

  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CPU_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_rdata0(rdata0), .o_rdata1(rdata1), .o_err(err),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CPU_PRIO(1'b1)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(p_gnt0), .o_gnt1(p_gnt1), .o_done0(p_done0), .o_done1(p_done1),
    .o_rdata0(p_rdata0), .o_rdata1(p_rdata1), .o_err(p_err),
    .o_mem_en(p_mem_en), .o_mem_we(p_mem_we), .o_mem_addr(p_mem_addr), .o_mem_wdata(p_mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );

  // Length of the most recent mem_en burst of the round-robin instance.
  always @(posedge clk) begin
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
    end else begin
      if (en_cnt != 0) en_last <= en_cnt;
      en_cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic mon(input string tag, input logic d0, input logic d1, input logic e,
                     input logic [DW-1:0] r0, input logic [DW-1:0] r1, input exp_t ex);
    chk({tag, "_done_port"}, 64'({d0, d1}), ex.port ? 64'h1 : 64'h2);
    chk({tag, "_err"}, 64'(e), 64'(ex.err));
    chk({tag, "_rdata"}, 64'(ex.port ? r1 : r0), 64'(ex.data));
  endtask

  always @(negedge clk) begin
    if (done0 || done1) begin
      if (q_rr.size() == 0) chk("rr_unexpected_done", 64'({done0, done1}), 64'h0);
      else mon("rr", done0, done1, err, rdata0, rdata1, q_rr.pop_front());
    end
    if (p_done0 || p_done1) begin
      if (q_p.size() == 0) chk("prio_unexpected_done", 64'({p_done0, p_done1}), 64'h0);
      else mon("prio", p_done0, p_done1, p_err, p_rdata0, p_rdata1, q_p.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic port_rr, input logic port_p, input logic e, input logic [DW-1:0] d);
    q_rr.push_back('{port: port_rr, err: e, data: d});
    q_p.push_back('{port: port_p, err: e, data: d});
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ctrl", 64'({gnt0, gnt1, done0, done1, err, mem_en, mem_we, mem_addr}), 64'h0);
    chk("rst_rdata", {rdata0, rdata1}, 64'h0);
    chk("rst_prio_ctrl", 64'({p_gnt0, p_gnt1, p_done0, p_done1, p_err, p_mem_en}), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single CPU read with immediate ack
    rd_drv = 32'hDEADBEEF;
    push2(1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    req0 = 1; we0 = 0; addr0 = 5'd5;
    @(negedge clk);
    chk("rd_gnt", 64'({gnt0, gnt1, mem_en}), 64'h4);
    tick();
    req0 = 0;
    @(negedge clk);
    chk("rd_mem", 64'({mem_en, mem_we, mem_addr, gnt0, gnt1}), 64'({1'b1, 1'b0, 5'd5, 2'b00}));
    tick();
    @(negedge clk);
    chk("rd_done_t2", 64'({done0, done1, mem_en}), 64'h4);
    repeat (2) tick();

    // DMA write; read data must come back as zero
    rd_drv = 32'hFFFFFFFF;
    push2(1'b1, 1'b1, 1'b0, 32'h0);
    req1 = 1; we1 = 1; addr1 = 5'd9; wdata1 = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt", 64'({gnt0, gnt1}), 64'h1);
    tick();
    req1 = 0;
    @(negedge clk);
    chk("wr_mem", 64'({mem_en, mem_we, mem_addr, mem_wdata}), 64'({1'b1, 1'b1, 5'd9, 32'h12345678}));
    tick();
    @(negedge clk);
    chk("rd_hold", 64'(rdata0), 64'hDEADBEEF);
    repeat (2) tick();

    // Continuous tie: RR alternates from port 0, priority always port 0
    rd_drv = 32'h00001111;
    we0 = 0; we1 = 0; addr0 = 5'd1; addr1 = 5'd2;
    push2(1'b0, 1'b0, 1'b0, 32'h00001111);
    push2(1'b1, 1'b0, 1'b0, 32'h00001111);
    push2(1'b0, 1'b0, 1'b0, 32'h00001111);
    push2(1'b1, 1'b0, 1'b0, 32'h00001111);
    push2(1'b1, 1'b1, 1'b0, 32'h00001111);
    req0 = 1; req1 = 1;
    repeat (8) tick();
    req0 = 0;
    repeat (2) tick();
    req1 = 0;
    repeat (3) tick();

    // Timeout on a DMA write: err with zeroed read data
    ack_mode = 1;
    push2(1'b1, 1'b1, 1'b1, 32'h0);
    req1 = 1; we1 = 1; addr1 = 5'd3; wdata1 = 32'hAAAA5555;
    tick();
    req1 = 0;
    repeat (TIMEOUT + 4) tick();
    chk("to_en_len", 64'(en_last), 64'(TIMEOUT));

    // Ack on the final allowed cycle wins over timeout
    ack_mode = 2; ack_at = TIMEOUT;
    rd_drv = 32'hCAFEF00D;
    push2(1'b0, 1'b0, 1'b0, 32'hCAFEF00D);
    req0 = 1; we0 = 0; addr0 = 5'd7;
    tick();
    req0 = 0;
    repeat (TIMEOUT + 4) tick();
    chk("col_en_len", 64'(en_last), 64'(TIMEOUT));

    // Reset during ACCESS drops the transaction and restores the pointer
    ack_mode = 1;
    req0 = 1; addr0 = 5'd4;
    tick();
    req0 = 0;
    @(negedge clk);
    chk("mid_en_before", 64'({mem_en, p_mem_en}), 64'h3);
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("mid_after_rst", 64'({mem_en, p_mem_en, done0, done1, p_done0, p_done1}), 64'h0);
    repeat (TIMEOUT + 5) tick();

    ack_mode = 0;
    rd_drv = 32'h5A5A5A5A;
    push2(1'b0, 1'b0, 1'b0, 32'h5A5A5A5A);
    req0 = 1; req1 = 1;
    @(negedge clk);
    chk("post_rst_tie", 64'({gnt0, gnt1, p_gnt0, p_gnt1}), 64'hA);
    tick();
    req0 = 0; req1 = 0;
    repeat (4) tick();

    chk("rr_queue_empty", 64'(q_rr.size()), 64'h0);
    chk("prio_queue_empty", 64'(q_p.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
